// File: rtl/forwarding_hazard_unit_if.sv
// rtl/forwarding_hazard_unit_if.sv - pipeline-side signal bundle for the forwarding/hazard unit
interface forwarding_hazard_unit_if #(
    parameter int RAW       = 5,
    parameter int NUM_SRC   = 2,
    parameter int CNT_WIDTH = 32
);
    logic                     in_id_valid;
    logic [NUM_SRC*RAW-1:0]   in_id_src;
    logic                     in_ex_valid;
    logic                     in_ex_regwrite;
    logic                     in_ex_memread;
    logic [RAW-1:0]           in_ex_rd;
    logic                     in_mem_valid;
    logic                     in_mem_regwrite;
    logic                     in_mem_memread;
    logic                     in_mem_data_ready;
    logic [RAW-1:0]           in_mem_rd;
    logic                     in_wb_valid;
    logic                     in_wb_regwrite;
    logic [RAW-1:0]           in_wb_rd;
    logic                     in_pipe_advance;
    logic                     in_flush;
    logic [NUM_SRC*2-1:0]     out_forward;
    logic                     out_stall;
    logic                     out_ex_bubble;
    logic [1:0]               out_state;
    logic [CNT_WIDTH-1:0]     out_stall_count;
    logic                     out_timeout;

    modport master (
        output in_id_valid, in_id_src,
        output in_ex_valid, in_ex_regwrite, in_ex_memread, in_ex_rd,
        output in_mem_valid, in_mem_regwrite, in_mem_memread, in_mem_data_ready, in_mem_rd,
        output in_wb_valid, in_wb_regwrite, in_wb_rd,
        output in_pipe_advance, in_flush,
        input  out_forward, out_stall, out_ex_bubble, out_state, out_stall_count, out_timeout
    );

    modport slave (
        input  in_id_valid, in_id_src,
        input  in_ex_valid, in_ex_regwrite, in_ex_memread, in_ex_rd,
        input  in_mem_valid, in_mem_regwrite, in_mem_memread, in_mem_data_ready, in_mem_rd,
        input  in_wb_valid, in_wb_regwrite, in_wb_rd,
        input  in_pipe_advance, in_flush,
        output out_forward, out_stall, out_ex_bubble, out_state, out_stall_count, out_timeout
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - operand bypass selects, load-use/mem-wait stalls, stall stats and watchdog
module forwarding_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2,
    parameter int CNT_WIDTH      = 32,
    parameter int MEM_WAIT_MAX   = 64
) (
    input logic                    clk,
    input logic                    reset_n,
    forwarding_hazard_unit_if.slave pif
);
    localparam int RAW  = REG_ADDR_WIDTH;
    localparam int WD_W = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        STALL_LU  = 2'b01,
        STALL_MEM = 2'b10
    } stateT;

    stateT                state, nextState;
    logic [NUM_SRC-1:0]   hazLu, hazMw;
    logic [NUM_SRC*2-1:0] fwdSel, fwdQ;
    logic                 bubbleQ;
    logic                 stall;
    logic [CNT_WIDTH-1:0] stallCnt;
    logic [WD_W-1:0]      memWaitCnt;
    logic                 timeoutQ;

    // Youngest producer wins; an EX load cannot bypass, so it falls through to older stages.
    always_comb begin
        hazLu  = '0;
        hazMw  = '0;
        fwdSel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pif.in_id_src[k*RAW +: RAW] != '0) begin
                hazLu[k] = pif.in_id_valid & pif.in_ex_valid & pif.in_ex_memread
                         & (pif.in_ex_rd == pif.in_id_src[k*RAW +: RAW]);
                hazMw[k] = pif.in_id_valid & pif.in_mem_valid & pif.in_mem_memread
                         & ~pif.in_mem_data_ready
                         & (pif.in_mem_rd == pif.in_id_src[k*RAW +: RAW]);
                if (pif.in_ex_valid && pif.in_ex_regwrite && !pif.in_ex_memread
                    && pif.in_ex_rd == pif.in_id_src[k*RAW +: RAW])
                    fwdSel[k*2 +: 2] = 2'b10;
                else if (pif.in_mem_valid && pif.in_mem_regwrite
                         && pif.in_mem_rd == pif.in_id_src[k*RAW +: RAW])
                    fwdSel[k*2 +: 2] = 2'b01;
                else if (pif.in_wb_valid && pif.in_wb_regwrite
                         && pif.in_wb_rd == pif.in_id_src[k*RAW +: RAW])
                    fwdSel[k*2 +: 2] = 2'b11;
            end
        end
    end

    assign stall = ((|hazLu) | (|hazMw)) & ~pif.in_flush & reset_n;

    always_comb begin
        nextState = RUN;
        if (pif.in_flush)
            nextState = RUN;
        else if (|hazMw)
            nextState = STALL_MEM;
        else if (|hazLu)
            nextState = STALL_LU;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= nextState;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwdQ    <= '0;
            bubbleQ <= 1'b0;
        end else if (pif.in_flush || (pif.in_pipe_advance && stall)) begin
            fwdQ    <= '0;
            bubbleQ <= 1'b1;
        end else if (pif.in_pipe_advance) begin
            fwdQ    <= fwdSel;
            bubbleQ <= ~pif.in_id_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stallCnt <= '0;
        else if (stall && stallCnt != '1)
            stallCnt <= stallCnt + 1'b1;
    end

    // Watchdog only flags the long wait; the stall itself keeps going until data arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memWaitCnt <= '0;
            timeoutQ   <= 1'b0;
        end else begin
            if (state != STALL_MEM)
                memWaitCnt <= '0;
            else if (memWaitCnt != WD_W'(MEM_WAIT_MAX))
                memWaitCnt <= memWaitCnt + 1'b1;
            if (state == STALL_MEM && memWaitCnt == WD_W'(MEM_WAIT_MAX - 1))
                timeoutQ <= 1'b1;
        end
    end

    assign pif.out_forward     = fwdQ;
    assign pif.out_stall       = stall;
    assign pif.out_ex_bubble   = bubbleQ;
    assign pif.out_state       = state;
    assign pif.out_stall_count = stallCnt;
    assign pif.out_timeout     = timeoutQ;
endmodule
